// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: XLEN, next-PC select codes,
// the canonical NOP encoding and the default reset vector.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_ALU    = 2'b10
    } pc_src_t;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'hBFC0_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, squash-to-NOP and load.
// Ports: clk, rst_n, hold/squash/load controls, misaligned update
//        (mis_set, mis_in), fetch-side data in, decode-side data out.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            squash,
    input  logic            load,
    input  logic            mis_set,
    input  logic            mis_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid,
    output logic            misaligned
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr      <= NOP;
            pc         <= '0;
            pc_plus4   <= '0;
            valid      <= 1'b0;
            misaligned <= 1'b0;
        end else if (hold) begin
            instr      <= instr;
        end else if (squash) begin
            // pc/pc_plus4 keep their last values; valid=0 marks them stale
            instr <= NOP;
            valid <= 1'b0;
            if (mis_set) begin
                misaligned <= mis_in;
            end
        end else if (load) begin
            instr      <= instr_in;
            pc         <= pc_in;
            pc_plus4   <= pc_plus4_in;
            valid      <= 1'b1;
            misaligned <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, imem request and IF/ID.
// Ports: clk, rst_n, hazard controls (stall_f, flush_d), execute redirect
//        (pc_src_e, pc_target_e, alu_result_e), imem handshake, IF/ID outputs.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic [1:0]  pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic [31:0] alu_result_e,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misaligned_d
);

    logic [31:0] pc_f;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4_f;
    logic [31:0] target;
    logic        redirect;
    logic        hold;
    logic        squash;
    logic        load;
    logic        mis_set;
    logic        req_q;

    assign imem_addr  = pc_f;
    assign imem_req   = req_q;
    assign pc_plus4_f = pc_f + 32'd4;

    // Code 2'b11 falls outside both redirect codes and acts as PLUS4.
    assign redirect = (pc_src_e == PCSRC_TARGET) ||
                      (pc_src_e == PCSRC_ALU);

    // jalr clears bit 0 before the word-align below.
    assign target = (pc_src_e == PCSRC_ALU) ?
                    (alu_result_e & ~32'h1) : pc_target_e;

    always_comb begin
        pc_next = pc_f;
        hold    = 1'b0;
        squash  = 1'b0;
        load    = 1'b0;
        mis_set = 1'b0;
        if (redirect) begin
            pc_next = {target[31:2], 2'b00};
            squash  = 1'b1;
            mis_set = 1'b1;
        end else if (stall_f) begin
            hold = 1'b1;
        end else if (flush_d) begin
            squash = 1'b1;
            if (imem_ready) begin
                pc_next = pc_plus4_f;
            end
        end else if (!imem_ready) begin
            squash = 1'b1;
        end else begin
            load    = 1'b1;
            pc_next = pc_plus4_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f  <= RESET_PC;
            req_q <= 1'b0;
        end else begin
            pc_f  <= pc_next;
            req_q <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP(NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .squash     (squash),
        .load       (load),
        .mis_set    (mis_set),
        .mis_in     (target[1:0] != 2'b00),
        .instr_in   (imem_rdata),
        .pc_in      (pc_f),
        .pc_plus4_in(pc_plus4_f),
        .instr      (instr_d),
        .pc         (pc_d),
        .pc_plus4   (pc_plus4_d),
        .valid      (valid_d),
        .misaligned (misaligned_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, redirects,
// stall/flush priority, imem wait states, PC wrap and async reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic        flush_d;
    logic [1:0]  pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] alu_result_e;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misaligned_d;

    int n_pass;
    int n_total;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .alu_result_e(alu_result_e),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .misaligned_d(misaligned_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag,
                         input logic [31:0] addr,
                         input logic [31:0] ins,
                         input logic        vld,
                         input logic        mis);
        check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".instr"}, instr_d, ins);
        check({tag, ".valid"}, {31'd0, valid_d}, {31'd0, vld});
        check({tag, ".mis"}, {31'd0, misaligned_d}, {31'd0, mis});
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst_n        = 1'b0;
        stall_f      = 1'b0;
        flush_d      = 1'b0;
        pc_src_e     = 2'b00;
        pc_target_e  = '0;
        alu_result_e = '0;
        imem_ready   = 1'b0;
        imem_rdata   = '0;

        #12;
        chk_d("rst", 32'hBFC0_0000, 32'h0000_0013, 1'b0, 1'b0);
        check("rst.pc_d", pc_d, 32'h0);
        check("rst.pc4_d", pc_plus4_d, 32'h0);
        check("rst.req", {31'd0, imem_req}, 32'd0);

        @(negedge clk);
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093;
        check("rel.addr", imem_addr, 32'hBFC0_0000);

        tick();
        check("seq0.req", {31'd0, imem_req}, 32'd1);
        chk_d("seq0", 32'hBFC0_0004, 32'h0050_0093, 1'b1, 1'b0);
        check("seq0.pc_d", pc_d, 32'hBFC0_0000);
        check("seq0.pc4_d", pc_plus4_d, 32'hBFC0_0004);

        imem_rdata = 32'h0010_8113;
        tick();
        chk_d("seq1", 32'hBFC0_0008, 32'h0010_8113, 1'b1, 1'b0);
        check("seq1.pc_d", pc_d, 32'hBFC0_0004);

        // branch redirect while fetching BFC00008
        imem_rdata  = 32'h0000_0013;
        pc_src_e    = 2'b01;
        pc_target_e = 32'hBFC0_0040;
        tick();
        chk_d("br", 32'hBFC0_0040, 32'h0000_0013, 1'b0, 1'b0);

        pc_src_e   = 2'b00;
        imem_rdata = 32'h0020_8193;
        tick();
        chk_d("br.res", 32'hBFC0_0044, 32'h0020_8193, 1'b1, 1'b0);
        check("br.res.pc_d", pc_d, 32'hBFC0_0040);

        // jalr to odd, misaligned address
        pc_src_e     = 2'b10;
        alu_result_e = 32'h0000_1007;
        tick();
        chk_d("jalr", 32'h0000_1004, 32'h0000_0013, 1'b0, 1'b1);

        pc_src_e   = 2'b00;
        imem_ready = 1'b0;
        tick();
        chk_d("jalr.wait", 32'h0000_1004, 32'h0000_0013, 1'b0, 1'b1);

        imem_ready = 1'b1;
        imem_rdata = 32'h0031_0213;
        tick();
        chk_d("jalr.ld", 32'h0000_1008, 32'h0031_0213, 1'b1, 1'b0);
        check("jalr.ld.pc_d", pc_d, 32'h0000_1004);

        // stall with flush: stall wins
        stall_f    = 1'b1;
        flush_d    = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        chk_d("stl0", 32'h0000_1008, 32'h0031_0213, 1'b1, 1'b0);
        flush_d = 1'b0;
        tick();
        chk_d("stl1", 32'h0000_1008, 32'h0031_0213, 1'b1, 1'b0);

        // redirect beats stall
        pc_src_e    = 2'b01;
        pc_target_e = 32'hBFC0_0010;
        tick();
        chk_d("stl.br", 32'hBFC0_0010, 32'h0000_0013, 1'b0, 1'b0);

        stall_f    = 1'b0;
        pc_src_e   = 2'b00;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_d("wait", 32'hBFC0_0010, 32'h0000_0013, 1'b0, 1'b0);
        end

        imem_ready = 1'b1;
        imem_rdata = 32'h0041_8293;
        tick();
        chk_d("wait.ld", 32'hBFC0_0014, 32'h0041_8293, 1'b1, 1'b0);
        check("wait.ld.pc_d", pc_d, 32'hBFC0_0010);

        // flush without stall: PC advances, IF/ID squashed
        flush_d = 1'b1;
        tick();
        chk_d("flush", 32'hBFC0_0018, 32'h0000_0013, 1'b0, 1'b0);
        flush_d = 1'b0;

        // code 2'b11 behaves as sequential
        pc_src_e    = 2'b11;
        pc_target_e = 32'h0000_4000;
        imem_rdata  = 32'h0000_0513;
        tick();
        chk_d("src3", 32'hBFC0_001C, 32'h0000_0513, 1'b1, 1'b0);

        // wrap at top of address space
        pc_src_e    = 2'b01;
        pc_target_e = 32'hFFFF_FFFC;
        tick();
        check("wrap.br", imem_addr, 32'hFFFF_FFFC);
        pc_src_e   = 2'b00;
        imem_rdata = 32'h0052_0313;
        tick();
        chk_d("wrap", 32'h0000_0000, 32'h0052_0313, 1'b1, 1'b0);
        check("wrap.pc_d", pc_d, 32'hFFFF_FFFC);
        check("wrap.pc4_d", pc_plus4_d, 32'h0000_0000);

        // short asynchronous reset pulse between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_d("arst", 32'hBFC0_0000, 32'h0000_0013, 1'b0, 1'b0);
        check("arst.pc_d", pc_d, 32'h0);
        check("arst.req", {31'd0, imem_req}, 32'd0);
        #2;
        rst_n = 1'b1;
        check("arst.rel", imem_addr, 32'hBFC0_0000);
        imem_rdata = 32'h0060_0393;
        tick();
        chk_d("arst.ld", 32'hBFC0_0004, 32'h0060_0393, 1'b1, 1'b0);
        check("arst.ld.pc_d", pc_d, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
